// File: rtl/vote_cu_multi.sv
// vote_cu_multi: parametrised voting control unit.
//   Counts one vote per armed ballot for N_CAND candidates, counts invalid
//   (multi-button) ballots, voids ballots that time out, saturates all counts,
//   tallies winner/tie sequentially on close and drives a tagged display.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   Power           machine enable
//   Close, Clear    level controls: close the poll / clear all counts
//   Ballot, Total,
//   Result          level buttons, acted on at their rising edge
//   IN              voter buttons, one bit per candidate
//   out, out_tag    registered display value and what it shows
//   armed, busy     ballot waiting for voter / tally in progress
//   tie             after tally: two or more candidates share the maximum
module vote_cu_multi #(
  parameter int N_CAND  = 4,
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         Power,
  input  logic                         Close,
  input  logic                         Clear,
  input  logic                         Ballot,
  input  logic                         Total,
  input  logic                         Result,
  input  logic [N_CAND-1:0]            IN,
  output logic [CNT_W-1:0]             out,
  output logic [$clog2(N_CAND+3)-1:0]  out_tag,
  output logic                         armed,
  output logic                         busy,
  output logic                         tie
);

  localparam int TAG_W = $clog2(N_CAND + 3);
  localparam int IDX_W = $clog2(N_CAND);
  localparam int TO_W  = $clog2(TIMEOUT);

  localparam logic [TAG_W-1:0] TAG_INV = TAG_W'(N_CAND);
  localparam logic [TAG_W-1:0] TAG_WIN = TAG_W'(N_CAND + 1);
  localparam logic [TAG_W-1:0] TAG_TOT = TAG_W'(N_CAND + 2);

  typedef enum logic [2:0] {
    S_OFF, S_IDLE, S_ARMED, S_HOLD, S_TALLY, S_CLOSED
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [N_CAND];
  logic [CNT_W-1:0]   cnt_d [N_CAND];
  logic [CNT_W-1:0]   inv_q, inv_d;
  logic [CNT_W-1:0]   tot_q, tot_d;
  logic [CNT_W-1:0]   lead_q, lead_d;
  logic [CNT_W-1:0]   out_q, out_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [TAG_W-1:0]   disp_q, disp_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               armed_q, armed_d;
  logic               busy_q, busy_d;
  logic               tie_q, tie_d;
  logic               closed_q, closed_d;
  logic               bal_p_q, tot_p_q, res_p_q;

  logic               bal_rise, tot_rise, res_rise;
  logic               do_clear, do_tally;
  logic [CNT_W-1:0]   tally_cur;
  logic [CNT_W-1:0]   disp_val;

  assign bal_rise  = Ballot & ~bal_p_q;
  assign tot_rise  = Total  & ~tot_p_q;
  assign res_rise  = Result & ~res_p_q;
  assign tally_cur = cnt_q[idx_q];

  assign out     = out_q;
  assign out_tag = tag_q;
  assign armed   = armed_q;
  assign busy    = busy_q;
  assign tie     = tie_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Value selected by the result-display index.
  always_comb begin
    disp_val = '0;
    if (disp_q < TAG_INV) begin
      disp_val = cnt_q[disp_q[IDX_W-1:0]];
    end else if (disp_q == TAG_INV) begin
      disp_val = inv_q;
    end else begin
      disp_val = tie_q ? '1 : CNT_W'(win_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    inv_d    = inv_q;
    tot_d    = tot_q;
    lead_d   = lead_q;
    out_d    = out_q;
    tag_d    = tag_q;
    disp_d   = disp_q;
    win_d    = win_q;
    idx_d    = idx_q;
    to_d     = to_q;
    armed_d  = armed_q;
    busy_d   = busy_q;
    tie_d    = tie_q;
    closed_d = closed_q;
    do_clear = 1'b0;
    do_tally = 1'b0;

    if (!Power) begin
      state_d = S_OFF;
      out_d   = '0;
      armed_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_OFF: state_d = closed_q ? S_CLOSED : S_IDLE;

        S_IDLE: begin
          if (Clear) begin
            do_clear = 1'b1;
          end else if (Close) begin
            do_tally = 1'b1;
          end else if (tot_rise) begin
            out_d = tot_q;
            tag_d = TAG_TOT;
          end else if (bal_rise) begin
            state_d = S_ARMED;
            armed_d = 1'b1;
            to_d    = TO_W'(TIMEOUT - 1);
          end
        end

        S_ARMED: begin
          if (Close) begin
            do_tally = 1'b1;
          end else if (IN != '0) begin
            if ($countones(IN) == 1) begin
              for (int unsigned i = 0; i < N_CAND; i++) begin
                if (IN[i]) cnt_d[i] = sat_inc(cnt_q[i]);
              end
            end else begin
              inv_d = sat_inc(inv_q);
            end
            tot_d   = sat_inc(tot_q);
            armed_d = 1'b0;
            state_d = S_HOLD;
          end else if (to_q == '0) begin
            armed_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            to_d = to_q - TO_W'(1);
          end
        end

        S_HOLD: begin
          if (Close) begin
            do_tally = 1'b1;
          end else if (IN == '0) begin
            state_d = S_IDLE;
          end
        end

        // Candidate idx_q is compared against the running leader; the
        // first candidate seeds the leader, so equal counts keep the
        // lowest index as winner.
        S_TALLY: begin
          if (idx_q == '0) begin
            lead_d = tally_cur;
            win_d  = '0;
            tie_d  = 1'b0;
          end else if (tally_cur > lead_q) begin
            lead_d = tally_cur;
            win_d  = idx_q;
            tie_d  = 1'b0;
          end else if (tally_cur == lead_q) begin
            tie_d = 1'b1;
          end
          if (idx_q == IDX_W'(N_CAND - 1)) begin
            busy_d   = 1'b0;
            out_d    = '0;
            tag_d    = '0;
            closed_d = 1'b1;
            state_d  = S_CLOSED;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end

        S_CLOSED: begin
          if (Clear) begin
            do_clear = 1'b1;
          end else if (res_rise) begin
            out_d  = disp_val;
            tag_d  = disp_q;
            disp_d = (disp_q == TAG_WIN) ? '0 : disp_q + TAG_W'(1);
          end else if (tot_rise) begin
            out_d = tot_q;
            tag_d = TAG_TOT;
          end
        end

        default: state_d = S_OFF;
      endcase
    end

    if (do_clear) begin
      for (int unsigned i = 0; i < N_CAND; i++) cnt_d[i] = '0;
      inv_d    = '0;
      tot_d    = '0;
      lead_d   = '0;
      tie_d    = 1'b0;
      win_d    = '0;
      out_d    = '0;
      tag_d    = '0;
      disp_d   = '0;
      closed_d = 1'b0;
      state_d  = S_IDLE;
    end

    if (do_tally) begin
      armed_d = 1'b0;
      busy_d  = 1'b1;
      idx_d   = '0;
      disp_d  = '0;
      state_d = S_TALLY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_OFF;
      for (int unsigned i = 0; i < N_CAND; i++) cnt_q[i] <= '0;
      inv_q    <= '0;
      tot_q    <= '0;
      lead_q   <= '0;
      out_q    <= '0;
      tag_q    <= '0;
      disp_q   <= '0;
      win_q    <= '0;
      idx_q    <= '0;
      to_q     <= '0;
      armed_q  <= 1'b0;
      busy_q   <= 1'b0;
      tie_q    <= 1'b0;
      closed_q <= 1'b0;
      bal_p_q  <= 1'b0;
      tot_p_q  <= 1'b0;
      res_p_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      inv_q    <= inv_d;
      tot_q    <= tot_d;
      lead_q   <= lead_d;
      out_q    <= out_d;
      tag_q    <= tag_d;
      disp_q   <= disp_d;
      win_q    <= win_d;
      idx_q    <= idx_d;
      to_q     <= to_d;
      armed_q  <= armed_d;
      busy_q   <= busy_d;
      tie_q    <= tie_d;
      closed_q <= closed_d;
      bal_p_q  <= Ballot;
      tot_p_q  <= Total;
      res_p_q  <= Result;
    end
  end

endmodule

// File: tb/tb_vote_cu_multi.sv
module tb_vote_cu_multi;

  localparam int N   = 4;
  localparam int TO  = 16;
  localparam int CW0 = 12;
  localparam int CW1 = 4;
  localparam int TW  = $clog2(N + 3);

  logic           clk = 1'b0;
  logic           rst, Power, Close, Clear, Ballot, Total, Result;
  logic [N-1:0]   IN;
  logic [CW0-1:0] out0;
  logic [CW1-1:0] out1;
  logic [TW-1:0]  tag0, tag1;
  logic           armed0, armed1, busy0, busy1, tie0, tie1;

  always #5 clk = ~clk;

  vote_cu_multi #(.N_CAND(N), .CNT_W(CW0), .TIMEOUT(TO)) dut0 (
    .clk(clk), .rst(rst), .Power(Power), .Close(Close), .Clear(Clear),
    .Ballot(Ballot), .Total(Total), .Result(Result), .IN(IN),
    .out(out0), .out_tag(tag0), .armed(armed0), .busy(busy0), .tie(tie0)
  );

  vote_cu_multi #(.N_CAND(N), .CNT_W(CW1), .TIMEOUT(TO)) dut1 (
    .clk(clk), .rst(rst), .Power(Power), .Close(Close), .Clear(Clear),
    .Ballot(Ballot), .Total(Total), .Result(Result), .IN(IN),
    .out(out1), .out_tag(tag1), .armed(armed1), .busy(busy1), .tie(tie1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one lane per DUT, differing only in saturation limit.
  typedef enum int {M_OFF, M_IDLE, M_ARMED, M_HOLD, M_TALLY, M_CLOSED} mst_t;
  mst_t m_st [2];
  int   m_cnt [2][N];
  int   m_inv [2], m_tot [2], m_out [2], m_tag [2];
  int   m_armed [2], m_busy [2], m_tie [2], m_win [2];
  int   m_left [2], m_tleft [2], m_disp [2], m_closed [2];
  int   maxv [2];
  bit   p_bal, p_tot, p_res;

  logic         s_rst, s_pow, s_close, s_clr, s_bal, s_tot, s_res;
  logic [N-1:0] s_in;

  always @(posedge clk) begin
    s_rst <= rst; s_pow <= Power; s_close <= Close; s_clr <= Clear;
    s_bal <= Ballot; s_tot <= Total; s_res <= Result; s_in <= IN;
  end

  task automatic m_clear(input int l);
    for (int i = 0; i < N; i++) m_cnt[l][i] = 0;
    m_inv[l] = 0; m_tot[l] = 0; m_tie[l] = 0; m_win[l] = 0;
    m_out[l] = 0; m_tag[l] = 0; m_disp[l] = 0; m_closed[l] = 0;
    m_st[l] = M_IDLE;
  endtask

  task automatic m_reset(input int l);
    m_clear(l);
    m_armed[l] = 0; m_busy[l] = 0; m_left[l] = 0; m_tleft[l] = 0;
    m_st[l] = M_OFF;
  endtask

  // Winner is the lowest index holding the maximum; tie when it occurs twice.
  task automatic m_open_tally(input int l);
    int mx, occ;
    mx = -1; occ = 0;
    for (int i = 0; i < N; i++) if (m_cnt[l][i] > mx) mx = m_cnt[l][i];
    for (int i = N - 1; i >= 0; i--)
      if (m_cnt[l][i] == mx) begin occ++; m_win[l] = i; end
    m_tie[l]   = (occ >= 2) ? 1 : 0;
    m_armed[l] = 0;
    m_busy[l]  = 1;
    m_tleft[l] = N;
    m_disp[l]  = 0;
    m_st[l]    = M_TALLY;
  endtask

  function automatic int m_inc(input int v, input int l);
    return (v < maxv[l]) ? v + 1 : v;
  endfunction

  task automatic m_step(input int l, input bit be, input bit te, input bit re);
    if (s_rst) begin
      m_reset(l);
    end else if (!s_pow) begin
      m_st[l] = M_OFF; m_out[l] = 0; m_armed[l] = 0; m_busy[l] = 0;
    end else begin
      case (m_st[l])
        M_OFF: m_st[l] = m_closed[l] ? M_CLOSED : M_IDLE;
        M_IDLE: begin
          if (s_clr) m_clear(l);
          else if (s_close) m_open_tally(l);
          else if (te) begin m_out[l] = m_tot[l]; m_tag[l] = N + 2; end
          else if (be) begin m_st[l] = M_ARMED; m_armed[l] = 1; m_left[l] = TO; end
        end
        M_ARMED: begin
          if (s_close) m_open_tally(l);
          else if (s_in != 0) begin
            if ($countones(s_in) == 1) begin
              for (int i = 0; i < N; i++) if (s_in[i]) m_cnt[l][i] = m_inc(m_cnt[l][i], l);
            end else begin
              m_inv[l] = m_inc(m_inv[l], l);
            end
            m_tot[l] = m_inc(m_tot[l], l);
            m_armed[l] = 0;
            m_st[l] = M_HOLD;
          end else begin
            m_left[l]--;
            if (m_left[l] == 0) begin m_armed[l] = 0; m_st[l] = M_IDLE; end
          end
        end
        M_HOLD: begin
          if (s_close) m_open_tally(l);
          else if (s_in == 0) m_st[l] = M_IDLE;
        end
        M_TALLY: begin
          m_tleft[l]--;
          if (m_tleft[l] == 0) begin
            m_busy[l] = 0; m_out[l] = 0; m_tag[l] = 0; m_closed[l] = 1;
            m_st[l] = M_CLOSED;
          end
        end
        M_CLOSED: begin
          if (s_clr) m_clear(l);
          else if (re) begin
            if (m_disp[l] < N) m_out[l] = m_cnt[l][m_disp[l]];
            else if (m_disp[l] == N) m_out[l] = m_inv[l];
            else m_out[l] = m_tie[l] ? maxv[l] : m_win[l];
            m_tag[l]  = m_disp[l];
            m_disp[l] = (m_disp[l] + 1) % (N + 2);
          end else if (te) begin
            m_out[l] = m_tot[l]; m_tag[l] = N + 2;
          end
        end
        default: m_st[l] = M_OFF;
      endcase
    end
  endtask

  // Model update and per-cycle comparison, away from the rising edge.
  initial begin
    bit be, te, re;
    maxv[0] = (1 << CW0) - 1;
    maxv[1] = (1 << CW1) - 1;
    m_reset(0); m_reset(1);
    p_bal = 0; p_tot = 0; p_res = 0;
    forever begin
      @(negedge clk);
      be = s_bal && !p_bal;
      te = s_tot && !p_tot;
      re = s_res && !p_res;
      for (int l = 0; l < 2; l++) m_step(l, be, te, re);
      if (s_rst) begin p_bal = 0; p_tot = 0; p_res = 0; end
      else begin p_bal = s_bal; p_tot = s_tot; p_res = s_res; end
      chk("out0", int'(out0), m_out[0]);
      chk("tag0", int'(tag0), m_tag[0]);
      chk("armed0", int'(armed0), m_armed[0]);
      chk("busy0", int'(busy0), m_busy[0]);
      if (m_st[0] != M_TALLY) chk("tie0", int'(tie0), m_tie[0]);
      chk("out1", int'(out1), m_out[1]);
      chk("tag1", int'(tag1), m_tag[1]);
      chk("armed1", int'(armed1), m_armed[1]);
      chk("busy1", int'(busy1), m_busy[1]);
      if (m_st[1] != M_TALLY) chk("tie1", int'(tie1), m_tie[1]);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic press(input int which);
    if (which == 0) Ballot = 1'b1; else if (which == 1) Total = 1'b1; else Result = 1'b1;
    tick(1);
    Ballot = 1'b0; Total = 1'b0; Result = 1'b0;
    tick(1);
  endtask

  task automatic vote(input int v, input int hold);
    Ballot = 1'b1;
    tick(1);
    Ballot = 1'b0;
    IN = N'(v);
    tick(hold);
    IN = '0;
    tick(2);
  endtask

  task automatic vote_n(input int v, input int n);
    repeat (n) vote(v, 2);
  endtask

  task automatic do_clear();
    Clear = 1'b1; tick(1); Clear = 1'b0; tick(1);
  endtask

  task automatic do_close();
    Close = 1'b1; tick(1); Close = 1'b0; tick(N + 1);
  endtask

  int exp_r0 [6];
  int exp_r1 [6];
  int n;

  initial begin
    rst = 1'b1; Power = 1'b0; Close = 1'b0; Clear = 1'b0;
    Ballot = 1'b0; Total = 1'b0; Result = 1'b0; IN = '0;
    tick(2);
    chk("rst_out", int'(out0), 0);
    chk("rst_tag", int'(tag0), 0);
    chk("rst_armed", int'(armed0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_tie", int'(tie0), 0);
    rst = 1'b0; Power = 1'b1;
    tick(1);
    do_clear();

    // Three single-button ballots.
    vote(1, 2); vote(1, 2); vote(4, 2);
    press(1);
    chk("total3_out", int'(out0), 3);
    chk("total3_tag", int'(tag0), 6);
    chk("model_cand0", m_cnt[0][0], 2);
    chk("model_cand2", m_cnt[0][2], 1);
    do_close();
    press(2); chk("res_c0", int'(out0), 2);
    press(2); chk("res_c1", int'(out0), 0);
    press(2); chk("res_c2", int'(out0), 1);
    press(2); chk("res_c3", int'(out0), 0);
    do_clear();

    // Multi-button ballots count as invalid.
    vote(5, 2); vote(15, 2);
    do_close();
    repeat (5) press(2);
    chk("invalid_out", int'(out0), 2);
    chk("invalid_tag", int'(tag0), 4);
    press(1);
    chk("invalid_total", int'(out0), 2);
    do_clear();

    // Held then changed button counts once.
    Ballot = 1'b1; tick(1); Ballot = 1'b0;
    IN = 4'b0001; tick(20); IN = 4'b0010; tick(3); IN = '0; tick(2);
    press(1);
    chk("hold_total", int'(out0), 1);
    chk("model_hold_c1", m_cnt[0][1], 0);
    do_clear();

    // Ballot timeout.
    Ballot = 1'b1; tick(1); Ballot = 1'b0;
    chk("to_armed_start", int'(armed0), 1);
    tick(TO - 1);
    chk("to_armed_last", int'(armed0), 1);
    tick(1);
    chk("to_armed_drop", int'(armed0), 0);
    vote(2, 2);
    press(1);
    chk("to_total", int'(out0), 1);
    do_clear();

    // Tie: 3,5,5,1.
    vote_n(1, 3); vote_n(2, 5); vote_n(4, 5); vote_n(8, 1);
    Close = 1'b1; tick(1); Close = 1'b0;
    n = 0;
    while (busy0 && n < 50) begin n++; tick(1); end
    chk("busy_cycles", n, N);
    exp_r0[0] = 3; exp_r0[1] = 5; exp_r0[2] = 5; exp_r0[3] = 1; exp_r0[4] = 0; exp_r0[5] = 4095;
    exp_r1[0] = 3; exp_r1[1] = 5; exp_r1[2] = 5; exp_r1[3] = 1; exp_r1[4] = 0; exp_r1[5] = 15;
    for (int i = 0; i < 6; i++) begin
      press(2);
      chk("tie_res_out0", int'(out0), exp_r0[i]);
      chk("tie_res_out1", int'(out1), exp_r1[i]);
      chk("tie_res_tag", int'(tag0), i);
    end
    chk("tie_flag", int'(tie0), 1);
    do_clear();

    // Unique winner: 3,5,2,1.
    vote_n(1, 3); vote_n(2, 5); vote_n(4, 2); vote_n(8, 1);
    do_close();
    repeat (6) press(2);
    chk("win_out", int'(out0), 1);
    chk("win_tag", int'(tag0), 5);
    chk("win_tie", int'(tie0), 0);
    do_clear();

    // Saturation on the narrow instance.
    vote_n(1, 17);
    press(1);
    chk("sat_total_w12", int'(out0), 17);
    chk("sat_total_w4", int'(out1), 15);
    do_close();
    press(2);
    chk("sat_cand_w4", int'(out1), 15);
    do_clear();

    // Power drop while armed voids the ballot.
    vote(1, 2);
    Ballot = 1'b1; tick(1); Ballot = 1'b0;
    chk("pwr_armed", int'(armed0), 1);
    Power = 1'b0; tick(3);
    chk("pwr_off_armed", int'(armed0), 0);
    chk("pwr_off_out", int'(out0), 0);
    Power = 1'b1; tick(2);
    press(1);
    chk("pwr_total", int'(out0), 1);

    // Clear in CLOSED returns to IDLE with everything zero.
    do_close();
    press(2);
    do_clear();
    chk("clr_out", int'(out0), 0);
    chk("clr_tag", int'(tag0), 0);
    Ballot = 1'b1; tick(1); Ballot = 1'b0;
    chk("clr_idle_arms", int'(armed0), 1);
    tick(TO + 1);

    // Randomised traffic against the model.
    for (int it = 0; it < 250; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 50) begin
        vote($urandom_range(0, 15), $urandom_range(1, 4));
      end else if (r < 62) begin
        press(1);
      end else if (r < 67) begin
        press(2);
      end else if (r < 73) begin
        do_close();
        repeat ($urandom_range(1, 8)) press(2);
        if ($urandom_range(0, 1) == 1) press(1);
        do_clear();
      end else if (r < 77) begin
        Power = 1'b0; tick($urandom_range(1, 3));
        Power = 1'b1; tick(2);
      end else if (r < 80) begin
        do_clear();
      end else begin
        IN = N'($urandom_range(0, 15));
        tick($urandom_range(1, 5));
        IN = '0;
        tick(1);
      end
    end

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
